ppu_vaddr: RTL and testbench

PPU VRAM address generator and background tile fetcher. It sits directly downstream of the PPU register interface and consumes these signals from it:
- scroll latches (fv/vt/v/ht/h/s);
- the `upd_cntrs` strobe;
- the `inc_addr` strobe and its increment amount.

It holds the live scroll counters and drives the 14-bit VRAM address. Outside rendering, the address serves CPU 0x2007 accesses. During rendering, a per-tile fetch sequence produces pattern/attribute bytes for the downstream background shifter.

---
 rtl/ppu_vaddr.sv | 251 +++++++++++++++++++++++++
 tb/tb_ppu_vaddr.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vaddr.sv
// ppu_vaddr: PPU VRAM address generator and background tile fetcher.
//
// Holds the live scroll counters (fv, v, h, vt, ht). These are loaded from the
// register-interface latches and stepped by 0x2007 accesses or by the
// rendering events. The block drives the 14-bit VRAM address: the counter
// address outside rendering, and the per-tile fetch address
// (NT, AT, pattern lo, pattern hi) while rendering.
//
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   pix_pulse_in              one-clk strobe per PPU dot
//   nes_x_in, nes_y_in        current dot / scanline
//   bg_en_in                  background rendering enable
//   ls_*_in                   scroll latches from the register interface
//   upd_cntrs_in              load all counters from the latches
//   inc_addr_in/_amt_in       0x2007 address increment (+1 / +32)
//   vram_d_in                 VRAM read data
//   vram_a_out                VRAM address
//   rendering_out             fetch mode active
//   tile_at/lo/hi_out         fetched tile palette bits and pattern planes
//   tile_vld_out              one-clk pulse when new tile data is valid
module ppu_vaddr (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        pix_pulse_in,
  input  logic [9:0]  nes_x_in,
  input  logic [9:0]  nes_y_in,
  input  logic        bg_en_in,
  input  logic [2:0]  ls_fv_in,
  input  logic [4:0]  ls_vt_in,
  input  logic        ls_v_in,
  input  logic [4:0]  ls_ht_in,
  input  logic        ls_h_in,
  input  logic        ls_s_in,
  input  logic        upd_cntrs_in,
  input  logic        inc_addr_in,
  input  logic        inc_addr_amt_in,
  input  logic [7:0]  vram_d_in,
  output logic [13:0] vram_a_out,
  output logic        rendering_out,
  output logic [1:0]  tile_at_out,
  output logic [7:0]  tile_lo_out,
  output logic [7:0]  tile_hi_out,
  output logic        tile_vld_out
);

  typedef enum logic [1:0] {ST_NT, ST_AT, ST_PLO, ST_PHI} state_t;

  // Scroll counters
  logic [2:0] fv_q, fv_d;
  logic       v_q, v_d;
  logic       h_q, h_d;
  logic [4:0] vt_q, vt_d;
  logic [4:0] ht_q, ht_d;

  // Fetch FSM and captured bytes
  state_t     state_q, state_d;
  logic       sync_q, sync_d;
  logic       s_q, s_d;
  logic [7:0] nt_q, nt_d;
  logic [1:0] at2_q, at2_d;
  logic [7:0] lo_q, lo_d;

  // Output registers
  logic [1:0] tile_at_q, tile_at_d;
  logic [7:0] tile_lo_q, tile_lo_d;
  logic [7:0] tile_hi_q, tile_hi_d;
  logic       tile_vld_q, tile_vld_d;

  logic        rendering;
  logic        fetch_dot;
  logic        fetch_active;
  logic [2:0]  k;
  logic        capture;
  logic        tile_done;
  logic [14:0] addr;
  logic [14:0] addr_inc;
  logic [7:0]  at_shifted;
  logic [13:0] fetch_a;

  assign rendering = bg_en_in & ((nes_y_in <= 10'd239) | (nes_y_in == 10'd261));
  assign fetch_dot = ((nes_x_in >= 10'd1)   && (nes_x_in <= 10'd256)) ||
                     ((nes_x_in >= 10'd321) && (nes_x_in <= 10'd336));
  assign fetch_active = rendering & fetch_dot;
  // Phase within the tile: (x-1) mod 8, computed on the low bits only.
  assign k = nes_x_in[2:0] - 3'd1;

  // A byte is captured on the second dot of each state, but only once the
  // FSM has locked onto a tile boundary (sync), so no partial tile is emitted.
  assign capture   = pix_pulse_in & fetch_active & sync_q & k[0];
  assign tile_done = capture & (state_q == ST_PHI);

  assign addr     = {fv_q, v_q, h_q, vt_q, ht_q};
  assign addr_inc = addr + (inc_addr_amt_in ? 15'd32 : 15'd1);

  // Attribute byte holds four 2-bit quadrants; pick one by vt[1], ht[1].
  assign at_shifted = vram_d_in >> {vt_q[1], ht_q[1], 1'b0};

  // Fetch address from the registered state only.
  always_comb begin
    fetch_a = 14'h2000 | {2'b00, v_q, h_q, vt_q, ht_q};
    case (state_q)
      ST_NT:   fetch_a = 14'h2000 | {2'b00, v_q, h_q, vt_q, ht_q};
      // Attribute table sits at offset 0x3C0 of the selected name table.
      ST_AT:   fetch_a = {2'b10, v_q, h_q, 4'b1111, vt_q[4:2], ht_q[4:2]};
      ST_PLO:  fetch_a = {1'b0, s_q, nt_q, 1'b0, fv_q};
      ST_PHI:  fetch_a = {1'b0, s_q, nt_q, 1'b1, fv_q};
      default: fetch_a = 14'h2000;
    endcase
  end

  // Fetch FSM next state
  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    if (!fetch_active) begin
      // Leaving the window or rendering dropping mid-tile abandons the tile.
      state_d = ST_NT;
      sync_d  = 1'b0;
    end else if (pix_pulse_in) begin
      if (k == 3'd0) begin
        state_d = ST_NT;
        sync_d  = 1'b1;
      end else if (sync_q && k[0]) begin
        case (state_q)
          ST_NT:   state_d = ST_AT;
          ST_AT:   state_d = ST_PLO;
          ST_PLO:  state_d = ST_PHI;
          default: state_d = ST_NT;
        endcase
      end
    end
  end

  // Byte capture and tile outputs
  always_comb begin
    s_d        = s_q;
    nt_d       = nt_q;
    at2_d      = at2_q;
    lo_d       = lo_q;
    tile_at_d  = tile_at_q;
    tile_lo_d  = tile_lo_q;
    tile_hi_d  = tile_hi_q;
    tile_vld_d = tile_done;
    if (capture) begin
      case (state_q)
        ST_NT: begin
          nt_d = vram_d_in;
          s_d  = ls_s_in;
        end
        ST_AT:  at2_d = at_shifted[1:0];
        ST_PLO: lo_d  = vram_d_in;
        default: begin
          tile_at_d = at2_q;
          tile_lo_d = lo_q;
          tile_hi_d = vram_d_in;
        end
      endcase
    end
  end

  // Counter updates; the latch load beats everything else in the same clk.
  always_comb begin
    fv_d = fv_q;
    v_d  = v_q;
    h_d  = h_q;
    vt_d = vt_q;
    ht_d = ht_q;
    if (upd_cntrs_in) begin
      fv_d = ls_fv_in;
      v_d  = ls_v_in;
      h_d  = ls_h_in;
      vt_d = ls_vt_in;
      ht_d = ls_ht_in;
    end else if (inc_addr_in && !rendering) begin
      {fv_d, v_d, h_d, vt_d, ht_d} = addr_inc;
    end else if (rendering && pix_pulse_in) begin
      // Coarse-x step after each completed tile; wrap flips name table.
      if (tile_done) begin
        ht_d = ht_q + 5'd1;
        if (ht_q == 5'd31) h_d = ~h_q;
      end
      // Fine-y step; vt 29 is the last visible row, 30/31 are attribute rows
      // that wrap without changing the name table.
      if (nes_x_in == 10'd256) begin
        fv_d = fv_q + 3'd1;
        if (fv_q == 3'd7) begin
          if (vt_q == 5'd29) begin
            vt_d = 5'd0;
            v_d  = ~v_q;
          end else begin
            vt_d = vt_q + 5'd1;
          end
        end
      end
      if (nes_x_in == 10'd257) begin
        ht_d = ls_ht_in;
        h_d  = ls_h_in;
      end
      if ((nes_y_in == 10'd261) && (nes_x_in >= 10'd280) && (nes_x_in <= 10'd304)) begin
        fv_d = ls_fv_in;
        vt_d = ls_vt_in;
        v_d  = ls_v_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fv_q       <= 3'd0;
      v_q        <= 1'b0;
      h_q        <= 1'b0;
      vt_q       <= 5'd0;
      ht_q       <= 5'd0;
      state_q    <= ST_NT;
      sync_q     <= 1'b0;
      s_q        <= 1'b0;
      nt_q       <= 8'd0;
      at2_q      <= 2'd0;
      lo_q       <= 8'd0;
      tile_at_q  <= 2'd0;
      tile_lo_q  <= 8'd0;
      tile_hi_q  <= 8'd0;
      tile_vld_q <= 1'b0;
    end else begin
      fv_q       <= fv_d;
      v_q        <= v_d;
      h_q        <= h_d;
      vt_q       <= vt_d;
      ht_q       <= ht_d;
      state_q    <= state_d;
      sync_q     <= sync_d;
      s_q        <= s_d;
      nt_q       <= nt_d;
      at2_q      <= at2_d;
      lo_q       <= lo_d;
      tile_at_q  <= tile_at_d;
      tile_lo_q  <= tile_lo_d;
      tile_hi_q  <= tile_hi_d;
      tile_vld_q <= tile_vld_d;
    end
  end

  assign vram_a_out    = rendering ? fetch_a : addr[13:0];
  assign rendering_out = rendering;
  assign tile_at_out   = tile_at_q;
  assign tile_lo_out   = tile_lo_q;
  assign tile_hi_out   = tile_hi_q;
  assign tile_vld_out  = tile_vld_q;

endmodule

// File: tb/tb_ppu_vaddr.sv
// Directed bench for ppu_vaddr: counter loads/increments, rendering events,
// per-tile fetch sequence (scoreboarded), and mid-tile reset.
module tb_ppu_vaddr;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        pix_pulse_in;
  logic [9:0]  nes_x_in;
  logic [9:0]  nes_y_in;
  logic        bg_en_in;
  logic [2:0]  ls_fv_in;
  logic [4:0]  ls_vt_in;
  logic        ls_v_in;
  logic [4:0]  ls_ht_in;
  logic        ls_h_in;
  logic        ls_s_in;
  logic        upd_cntrs_in;
  logic        inc_addr_in;
  logic        inc_addr_amt_in;
  logic [7:0]  vram_d_in;
  logic [13:0] vram_a_out;
  logic        rendering_out;
  logic [1:0]  tile_at_out;
  logic [7:0]  tile_lo_out;
  logic [7:0]  tile_hi_out;
  logic        tile_vld_out;

  ppu_vaddr dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .pix_pulse_in    (pix_pulse_in),
    .nes_x_in        (nes_x_in),
    .nes_y_in        (nes_y_in),
    .bg_en_in        (bg_en_in),
    .ls_fv_in        (ls_fv_in),
    .ls_vt_in        (ls_vt_in),
    .ls_v_in         (ls_v_in),
    .ls_ht_in        (ls_ht_in),
    .ls_h_in         (ls_h_in),
    .ls_s_in         (ls_s_in),
    .upd_cntrs_in    (upd_cntrs_in),
    .inc_addr_in     (inc_addr_in),
    .inc_addr_amt_in (inc_addr_amt_in),
    .vram_d_in       (vram_d_in),
    .vram_a_out      (vram_a_out),
    .rendering_out   (rendering_out),
    .tile_at_out     (tile_at_out),
    .tile_lo_out     (tile_lo_out),
    .tile_hi_out     (tile_hi_out),
    .tile_vld_out    (tile_vld_out)
  );

  always #10 clk_in = ~clk_in;

  typedef struct packed {
    logic [1:0] at;
    logic [7:0] lo;
    logic [7:0] hi;
  } tile_t;

  tile_t sb[$];
  int checks   = 0;
  int failures = 0;
  int n_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after each dot's clock edge: a pulse is expected exactly when
  // the scoreboard holds a tile pushed on the preceding k==7 dot.
  task automatic check_vld();
    tile_t t;
    chk("tile_vld", {31'd0, tile_vld_out}, {31'd0, (sb.size() != 0)});
    if (tile_vld_out === 1'b1) n_pulses++;
    if (sb.size() != 0) begin
      t = sb.pop_front();
      if (tile_vld_out === 1'b1) begin
        chk("tile_at", {30'd0, tile_at_out}, {30'd0, t.at});
        chk("tile_lo", {24'd0, tile_lo_out}, {24'd0, t.lo});
        chk("tile_hi", {24'd0, tile_hi_out}, {24'd0, t.hi});
        $display("tile at=%0d lo=0x%02h hi=0x%02h", tile_at_out, tile_lo_out, tile_hi_out);
      end
    end
  endtask

  task automatic dot(input int x, input int y, input logic [7:0] d,
                     input logic chk_a, input logic [13:0] exp_a);
    nes_x_in     = 10'(x);
    nes_y_in     = 10'(y);
    vram_d_in    = d;
    pix_pulse_in = 1'b1;
    #1;
    if (chk_a) chk("fetch_a", {18'd0, vram_a_out}, {18'd0, exp_a});
    @(posedge clk_in); #1;
    pix_pulse_in = 1'b0;
    check_vld();
  endtask

  task automatic load(input logic [2:0] fv, input logic v, input logic h,
                      input logic [4:0] vt, input logic [4:0] ht, input logic s);
    ls_fv_in = fv; ls_v_in = v; ls_h_in = h; ls_vt_in = vt; ls_ht_in = ht; ls_s_in = s;
    upd_cntrs_in = 1'b1;
    @(posedge clk_in); #1;
    upd_cntrs_in = 1'b0;
  endtask

  task automatic inc(input logic amt);
    inc_addr_in = 1'b1; inc_addr_amt_in = amt;
    @(posedge clk_in); #1;
    inc_addr_in = 1'b0;
  endtask

  // Read the counter address by dropping out of rendering.
  task automatic peek_a(input string tag, input logic [13:0] exp);
    bg_en_in = 1'b0;
    #1;
    chk(tag, {18'd0, vram_a_out}, {18'd0, exp});
  endtask

  task automatic run_tile(input int x0, input int y, input logic [7:0] nt, input logic [7:0] at,
                          input logic [7:0] lo, input logic [7:0] hi, input logic [1:0] eat,
                          input logic [13:0] ea_nt, input logic [13:0] ea_plo);
    tile_t t;
    logic [7:0]  d;
    logic        ck;
    logic [13:0] ea;
    bg_en_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d  = (k < 2) ? nt : (k < 4) ? at : (k < 6) ? lo : hi;
      ck = 1'b1;
      ea = ea_nt;
      if (k >= 2 && k < 4) ck = 1'b0;
      else if (k >= 4 && k < 6) ea = ea_plo;
      else if (k >= 6) ea = ea_plo | 14'h0008;
      if (k == 7) begin
        t.at = eat; t.lo = lo; t.hi = hi;
        sb.push_back(t);
      end
      dot(x0 + k, y, d, ck, ea);
    end
  endtask

  initial begin
    rst_n_in = 1'b0; pix_pulse_in = 1'b0; nes_x_in = '0; nes_y_in = '0; bg_en_in = 1'b0;
    ls_fv_in = '0; ls_vt_in = '0; ls_v_in = 1'b0; ls_ht_in = '0; ls_h_in = 1'b0; ls_s_in = 1'b0;
    upd_cntrs_in = 1'b0; inc_addr_in = 1'b0; inc_addr_amt_in = 1'b0; vram_d_in = '0;
    repeat (2) @(posedge clk_in);
    #1;

    // Reset state
    chk("rst_vram_a", {18'd0, vram_a_out}, 32'd0);
    chk("rst_tile_at", {30'd0, tile_at_out}, 32'd0);
    chk("rst_tile_lo", {24'd0, tile_lo_out}, 32'd0);
    chk("rst_tile_hi", {24'd0, tile_hi_out}, 32'd0);
    chk("rst_tile_vld", {31'd0, tile_vld_out}, 32'd0);
    chk("rendering_off", {31'd0, rendering_out}, 32'd0);
    bg_en_in = 1'b1; nes_y_in = 10'd239; #1;
    chk("rendering_y239", {31'd0, rendering_out}, 32'd1);
    nes_y_in = 10'd240; #1;
    chk("rendering_y240", {31'd0, rendering_out}, 32'd0);
    nes_y_in = 10'd261; #1;
    chk("rendering_y261", {31'd0, rendering_out}, 32'd1);
    bg_en_in = 1'b0; nes_y_in = 10'd0;
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Latch load: visible the clk after the strobe
    ls_fv_in = 3'd5; ls_v_in = 1'b1; ls_h_in = 1'b0; ls_vt_in = 5'h1A; ls_ht_in = 5'h07;
    upd_cntrs_in = 1'b1; #1;
    chk("upd_same_clk", {18'd0, vram_a_out}, 32'h0000);
    @(posedge clk_in); #1;
    upd_cntrs_in = 1'b0;
    chk("upd_load", {18'd0, vram_a_out}, 32'h1B47);

    // 0x2007 increments
    inc_addr_in = 1'b1; inc_addr_amt_in = 1'b0; #1;
    chk("inc_pre", {18'd0, vram_a_out}, 32'h1B47);
    @(posedge clk_in); #1;
    inc_addr_in = 1'b0;
    chk("inc_plus1", {18'd0, vram_a_out}, 32'h1B48);
    load(3'd3, 1'b1, 1'b1, 5'd31, 5'd31, 1'b0);
    chk("a_3fff", {18'd0, vram_a_out}, 32'h3FFF);
    inc(1'b0);
    chk("inc_3fff", {18'd0, vram_a_out}, 32'h0000);
    load(3'd7, 1'b1, 1'b1, 5'd31, 5'd5, 1'b0);
    chk("a_7fe5", {18'd0, vram_a_out}, 32'h3FE5);
    inc(1'b1);
    chk("inc32_wrap", {18'd0, vram_a_out}, 32'h0005);
    bg_en_in = 1'b1; nes_x_in = 10'd0; nes_y_in = 10'd0;
    inc(1'b0);
    peek_a("inc_ignored_rendering", 14'h0005);

    // Tile fetches
    load(3'd2, 1'b0, 1'b0, 5'd2, 5'd3, 1'b1);
    nes_x_in = 10'd0;
    run_tile(1,  0, 8'h5A, 8'hC4, 8'h3C, 8'h81, 2'd3, 14'h2043, 14'h15A2);
    run_tile(9,  0, 8'h96, 8'h1B, 8'h11, 8'h22, 2'd1, 14'h2044, 14'h1962);
    load(3'd2, 1'b0, 1'b0, 5'd0, 5'd31, 1'b1);
    run_tile(17, 0, 8'h03, 8'h1B, 8'h55, 8'hAA, 2'd2, 14'h201F, 14'h1032);
    run_tile(25, 0, 8'h04, 8'h1B, 8'h66, 8'h99, 2'd3, 14'h2400, 14'h1042);
    peek_a("ht_wrap_a", 14'h2401);

    // Fine-y increment
    load(3'd7, 1'b0, 1'b0, 5'd29, 5'd0, 1'b0);
    bg_en_in = 1'b1;
    dot(256, 0, 8'h00, 1'b0, 14'h0000);
    peek_a("finey_vt29", 14'h0800);
    load(3'd7, 1'b0, 1'b1, 5'd31, 5'd0, 1'b0);
    bg_en_in = 1'b1;
    dot(256, 0, 8'h00, 1'b0, 14'h0000);
    peek_a("finey_vt31", 14'h0400);

    // Horizontal copy at x=257, vertical copy on pre-render line
    ls_ht_in = 5'h15; ls_h_in = 1'b0;
    bg_en_in = 1'b1;
    dot(257, 0, 8'h00, 1'b0, 14'h0000);
    peek_a("hcopy", 14'h0015);
    ls_fv_in = 3'd3; ls_vt_in = 5'd10; ls_v_in = 1'b1;
    bg_en_in = 1'b1;
    dot(290, 261, 8'h00, 1'b0, 14'h0000);
    peek_a("vcopy", 14'h3955);
    ls_fv_in = 3'd0;
    bg_en_in = 1'b1;
    dot(305, 261, 8'h00, 1'b0, 14'h0000);
    peek_a("vcopy_outside", 14'h3955);

    // Load wins over a same-clk fine-y event
    ls_fv_in = 3'd1; ls_v_in = 1'b0; ls_h_in = 1'b0; ls_vt_in = 5'd4; ls_ht_in = 5'd2;
    upd_cntrs_in = 1'b1; bg_en_in = 1'b1;
    dot(256, 0, 8'h00, 1'b0, 14'h0000);
    upd_cntrs_in = 1'b0;
    peek_a("upd_beats_finey", 14'h1082);

    // Reset mid-tile at k=5, then a clean tile
    load(3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    bg_en_in = 1'b1;
    for (int k = 0; k < 5; k++) dot(33 + k, 1, 8'hA5, 1'b0, 14'h0000);
    nes_x_in = 10'd38; vram_d_in = 8'h5A; pix_pulse_in = 1'b1;
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("midrst_tile_at", {30'd0, tile_at_out}, 32'd0);
    chk("midrst_tile_lo", {24'd0, tile_lo_out}, 32'd0);
    chk("midrst_tile_hi", {24'd0, tile_hi_out}, 32'd0);
    chk("midrst_tile_vld", {31'd0, tile_vld_out}, 32'd0);
    @(posedge clk_in); #1;
    pix_pulse_in = 1'b0;
    rst_n_in = 1'b1;
    dot(39, 1, 8'hFF, 1'b0, 14'h0000);
    dot(40, 1, 8'hFF, 1'b0, 14'h0000);
    run_tile(41, 1, 8'h12, 8'hE6, 8'h77, 8'hEE, 2'd2, 14'h2000, 14'h0120);

    chk("sb_empty", sb.size(), 32'd0);
    chk("pulse_count", n_pulses, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
